// File: rtl/cpu_mem_pkg.sv
// Shared memory-side definitions: store sizes, drain FSM states
// and the store buffer entry layout.
package cpu_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int WADDR_W = 30;
    localparam int BE_W    = 4;
    localparam int DATA_W  = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [BE_W-1:0]    be;
        logic [DATA_W-1:0]  data;
    } sq_entry_t;

endpackage

// File: rtl/store_align.sv
// Combinational store lane aligner.
// Ports: offset/size/data_in in; data_out, byte_en, illegal out.
module store_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [3:0]  byte_en,
    output logic        illegal
);

    always_comb begin
        data_out = '0;
        byte_en  = '0;
        illegal  = 1'b0;
        unique case (size)
            SZ_BYTE: begin
                byte_en  = 4'b0001 << offset;
                data_out = {24'b0, data_in[7:0]} << {offset, 3'b000};
            end
            SZ_HALF: begin
                illegal = offset[0];
                if (offset[1]) begin
                    byte_en  = 4'b1100;
                    data_out = {data_in[15:0], 16'b0};
                end else begin
                    byte_en  = 4'b0011;
                    data_out = {16'b0, data_in[15:0]};
                end
            end
            SZ_WORD: begin
                illegal  = |offset;
                byte_en  = 4'b1111;
                data_out = data_in;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_write_buffer.sv
// In-order store buffer: aligns sb/sh/sw, queues them, drains to memory.
// Ports: Store* push side, MemWr* req/ack drain, LoadAddr/LoadConflict.
module store_write_buffer
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             StoreValid,
    output logic             StoreReady,
    input  logic [31:0]      StoreAddr,
    input  logic [31:0]      StoreData,
    input  logic [1:0]       StoreSize,
    output logic             MisalignErr,
    output logic             MemWrReq,
    output logic [31:0]      MemWrAddr,
    output logic [31:0]      MemWrData,
    output logic [3:0]       MemWrByteEn,
    input  logic             MemWrAck,
    input  logic [31:0]      LoadAddr,
    output logic             LoadConflict,
    output logic             Empty,
    output logic [PTR_W:0]   Count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    sq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    drain_state_e     state_q, state_d;
    logic             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [3:0]       be_q, be_d;
    logic             err_q, err_d;

    logic [31:0] al_data;
    logic [3:0]  al_be;
    logic        al_illegal;
    logic        store_ok;
    logic        push;
    logic        pop;
    sq_entry_t   new_entry;
    sq_entry_t   head_entry;

    store_align u_align (
        .offset   (StoreAddr[1:0]),
        .size     (StoreSize),
        .data_in  (StoreData),
        .data_out (al_data),
        .byte_en  (al_be),
        .illegal  (al_illegal)
    );

    assign StoreReady = count_q < FULL_CNT;
    assign store_ok   = StoreValid & StoreReady;
    assign push       = store_ok & ~al_illegal;
    assign pop        = (state_q == ST_WRITE) & MemWrAck;
    assign new_entry  = '{waddr: StoreAddr[31:2], be: al_be, data: al_data};
    assign head_entry = mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = store_ok & al_illegal;
        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    // The in-flight entry stays in the queue until its ack, so the
    // head is always the entry being (or about to be) written.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_WRITE;
                    req_d   = 1'b1;
                    addr_d  = {head_entry.waddr, 2'b00};
                    data_d  = head_entry.data;
                    be_d    = head_entry.be;
                end
            end
            ST_WRITE: begin
                if (MemWrAck) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
        endcase
    end

    // A slot is valid when its distance from head is below count.
    always_comb begin
        logic [PTR_W-1:0] rel;
        rel          = '0;
        LoadConflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = PTR_W'(i) - head_q;
            if (({1'b0, rel} < count_q) &&
                (mem_q[i].waddr == LoadAddr[31:2]))
                LoadConflict = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: '0};
        end else if (push) begin
            mem_q[tail_q] <= new_entry;
        end
    end

    assign MisalignErr = err_q;
    assign MemWrReq    = req_q;
    assign MemWrAddr   = addr_q;
    assign MemWrData   = data_q;
    assign MemWrByteEn = be_q;
    assign Empty       = (count_q == '0);
    assign Count       = count_q;

endmodule
